// File: rtl/duck_hunt_pkg.sv
// Shared types and constants for the Duck Hunt game logic.
package duck_hunt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        FINISH
    } sched_state_t;

    localparam int NUM_STAGES_DEFAULT = 4;

    localparam int STG_INPUT = 0;
    localparam int STG_DUCK  = 1;
    localparam int STG_HIT   = 2;
    localparam int STG_SCORE = 3;

    // 25.125 MHz / 60 Hz, used by the frame-rate divider that produces tick60.
    localparam int FRAME_DIV = 418_750;

endpackage

// File: rtl/stage_timer.sv
// Clearable up-counter that flags when a stage has waited STAGE_TIMEOUT cycles.
module stage_timer #(
    parameter int STAGE_TIMEOUT = 65535
) (
    input  logic clk25m,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(STAGE_TIMEOUT) + 1;

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk25m) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(STAGE_TIMEOUT - 1));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: on each accepted 60 Hz tick, runs the update stages in order.
module frame_scheduler
    import duck_hunt_pkg::*;
#(
    parameter int NUM_STAGES    = NUM_STAGES_DEFAULT,
    parameter int STAGE_TIMEOUT = 65535,
    parameter int FC_W          = 16
) (
    input  logic                          clk25m,
    input  logic                          reset,
    input  logic                          tick60,
    input  logic                          pause,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_start,
    output logic [$clog2(NUM_STAGES)-1:0] stage_active,
    output logic                          busy,
    output logic                          frame_done,
    output logic [FC_W-1:0]               frame_count,
    output logic [7:0]                    overrun_count,
    output logic                          timeout_err
);

    localparam int            IW       = $clog2(NUM_STAGES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [IW-1:0] idx;
    logic          timer_expired;
    logic          cur_done;
    logic          advance;
    logic          last_stage;
    logic          accept_tick;

    // Only the current stage's done bit matters, and only while waiting on it.
    assign cur_done    = stage_done[idx];
    assign advance     = (state == WAIT) && (cur_done || timer_expired);
    assign last_stage  = (idx == LAST_IDX);
    assign accept_tick = (state == IDLE) && tick60 && !pause;

    stage_timer #(
        .STAGE_TIMEOUT(STAGE_TIMEOUT)
    ) u_stage_timer (
        .clk25m (clk25m),
        .reset  (reset),
        .clear  (state == START),
        .enable (state == WAIT),
        .expired(timer_expired)
    );

    always_ff @(posedge clk25m) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignments up front keep combinational blocks latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_tick) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (advance) state_nxt = last_stage ? FINISH : START;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stage_start = '0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            START:   stage_start[idx] = 1'b1;
            FINISH:  frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk25m) begin
        if (reset) begin
            idx           <= IW'(STG_INPUT);
            frame_count   <= '0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (accept_tick) begin
                idx <= IW'(STG_INPUT);
            end else if (advance && !last_stage) begin
                idx <= idx + IW'(1);
            end

            if (state == FINISH) begin
                frame_count <= frame_count + FC_W'(1);
            end

            // A tick arriving mid-frame is dropped rather than queued.
            if (tick60 && busy && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end

            // Done on the terminal cycle wins, so no error in that case.
            if (state == WAIT && timer_expired && !cur_done) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign stage_active = idx;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: expected start/done events queued by stimulus, checked by a monitor.
module tb_frame_scheduler;
    import duck_hunt_pkg::*;

    localparam int NS = 4;

    logic          clk25m = 1'b0;
    logic          reset;
    logic          tick60;
    logic          pause;
    logic [NS-1:0] resp_done;
    logic [NS-1:0] man_done;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_start;
    logic [1:0]    stage_active;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [7:0]    overrun_count;
    logic          timeout_err;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } evt_t;

    evt_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   resp_delay[NS];
    logic resp_en;
    int   t0;

    assign stage_done = resp_done | man_done;

    frame_scheduler #(
        .NUM_STAGES   (NS),
        .STAGE_TIMEOUT(16),
        .FC_W         (16)
    ) dut (
        .clk25m       (clk25m),
        .reset        (reset),
        .tick60       (tick60),
        .pause        (pause),
        .stage_done   (stage_done),
        .stage_start  (stage_start),
        .stage_active (stage_active),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .overrun_count(overrun_count),
        .timeout_err  (timeout_err)
    );

    always #20 clk25m = ~clk25m;

    always @(posedge clk25m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk25m);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic pulse_tick();
        tick60 = 1'b1;
        step(1);
        tick60 = 1'b0;
    endtask

    task automatic push(input int c, input logic [4:0] v);
        evt_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        resp_delay[0] = d0;
        resp_delay[1] = d1;
        resp_delay[2] = d2;
        resp_delay[3] = d3;
    endtask

    // Monitor: every start pulse or frame_done must match the head of the queue.
    always @(negedge clk25m) begin : monitor
        evt_t e;
        if (stage_start != '0 || frame_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {27'd0, frame_done, stage_start}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_value", {27'd0, frame_done, stage_start}, {27'd0, e.val});
            end
        end
    end

    // Stage model: answers each start with a one-cycle done after resp_delay cycles (<=0: never).
    initial begin : responder
        int k;
        resp_done = '0;
        forever begin
            @(negedge clk25m);
            if (resp_en && stage_start != '0) begin
                k = -1;
                for (int i = 0; i < NS; i++) if (stage_start[i]) k = i;
                if (k >= 0 && resp_delay[k] > 0) begin
                    repeat (resp_delay[k]) @(posedge clk25m);
                    #1 resp_done[k] = 1'b1;
                    @(posedge clk25m);
                    #1 resp_done = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset    = 1'b1;
        tick60   = 1'b0;
        pause    = 1'b0;
        resp_en  = 1'b1;
        man_done = '0;
        set_delays(3, 3, 3, 3);

        step(3);
        check("rst_stage_start", stage_start, 0);
        check("rst_stage_active", stage_active, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun", overrun_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        // Single frame, tick at cycle 10, done 3 cycles after each start.
        wait_until(10);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 5, 5'b00010);
        push(t0 + 9, 5'b00100);
        push(t0 + 13, 5'b01000);
        push(t0 + 17, 5'b10000);
        pulse_tick();
        wait_until(t0 + 17);
        check("single_busy_finish", busy, 1);
        wait_until(t0 + 18);
        check("single_frame_count", frame_count, 1);
        check("single_busy_low", busy, 0);
        check("single_stage_active", stage_active, STG_SCORE);

        // Done on the same cycle as the timeout counts as done.
        wait_until(t0 + 22);
        set_delays(16, 1, 1, 1);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 18, 5'b00010);
        push(t0 + 20, 5'b00100);
        push(t0 + 22, 5'b01000);
        push(t0 + 24, 5'b10000);
        pulse_tick();
        wait_until(t0 + 25);
        check("edge_frame_count", frame_count, 2);
        check("edge_no_timeout", timeout_err, 0);

        // Stage 2 never answers: forced advance after 16 waiting cycles.
        wait_until(t0 + 28);
        set_delays(3, 3, -1, 3);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 5, 5'b00010);
        push(t0 + 9, 5'b00100);
        push(t0 + 26, 5'b01000);
        push(t0 + 30, 5'b10000);
        pulse_tick();
        wait_until(t0 + 10);
        check("timeout_err_before", timeout_err, 0);
        wait_until(t0 + 31);
        check("timeout_frame_count", frame_count, 3);
        check("timeout_err_set", timeout_err, 1);

        // Three ticks while stage 1 waits are dropped and counted.
        wait_until(t0 + 33);
        set_delays(1, 10, 1, 1);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 3, 5'b00010);
        push(t0 + 14, 5'b00100);
        push(t0 + 16, 5'b01000);
        push(t0 + 18, 5'b10000);
        pulse_tick();
        wait_until(t0 + 5);
        pulse_tick();
        wait_until(t0 + 7);
        pulse_tick();
        wait_until(t0 + 9);
        pulse_tick();
        wait_until(t0 + 19);
        check("overrun_count_3", overrun_count, 3);
        check("overrun_frame_count", frame_count, 4);
        check("timeout_err_sticky", timeout_err, 1);

        // Paused in IDLE: ticks ignored and not counted.
        pause = 1'b1;
        repeat (5) begin
            pulse_tick();
            step(2);
        end
        check("pause_overrun", overrun_count, 3);
        check("pause_busy", busy, 0);
        check("pause_frame_count", frame_count, 4);
        pause = 1'b0;
        step(2);

        // Pause raised during stage 2 does not abort the frame.
        set_delays(1, 1, 5, 1);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 3, 5'b00010);
        push(t0 + 5, 5'b00100);
        push(t0 + 11, 5'b01000);
        push(t0 + 13, 5'b10000);
        pulse_tick();
        wait_until(t0 + 7);
        pause = 1'b1;
        wait_until(t0 + 14);
        check("pause_mid_frame_count", frame_count, 5);
        check("pause_mid_busy", busy, 0);
        pause = 1'b0;
        step(2);

        // Stray done bits: ignored in START and for non-current stages.
        resp_en = 1'b0;
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 5, 5'b00010);
        push(t0 + 7, 5'b00100);
        push(t0 + 9, 5'b01000);
        push(t0 + 11, 5'b10000);
        pulse_tick();
        man_done = 4'b1111;
        step(1);
        man_done = 4'b1110;
        step(2);
        man_done = 4'b0001;
        step(1);
        man_done = 4'b1111;
        wait_until(t0 + 12);
        man_done = '0;
        check("stray_frame_count", frame_count, 6);
        resp_en = 1'b1;
        step(2);

        // Reset during stage 1 wait aborts the frame.
        set_delays(1, 12, 1, 1);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 3, 5'b00010);
        pulse_tick();
        wait_until(t0 + 6);
        reset = 1'b1;
        step(1);
        check("midrst_busy", busy, 0);
        check("midrst_stage_start", stage_start, 0);
        check("midrst_stage_active", stage_active, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_overrun", overrun_count, 0);
        check("midrst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        wait_until(t0 + 20);
        check("midrst_no_frame", frame_count, 0);

        set_delays(1, 1, 1, 1);
        t0 = cyc;
        push(t0 + 1, 5'b00001);
        push(t0 + 3, 5'b00010);
        push(t0 + 5, 5'b00100);
        push(t0 + 7, 5'b01000);
        push(t0 + 9, 5'b10000);
        pulse_tick();
        wait_until(t0 + 10);
        check("restart_frame_count", frame_count, 1);
        check("restart_stage_active", stage_active, STG_SCORE);

        // tick60 held for 300 cycles over timed-out frames: overrun saturates.
        set_delays(-1, -1, -1, -1);
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            push(t0 + 70 * k + 1, 5'b00001);
            push(t0 + 70 * k + 18, 5'b00010);
            push(t0 + 70 * k + 35, 5'b00100);
            push(t0 + 70 * k + 52, 5'b01000);
            push(t0 + 70 * k + 69, 5'b10000);
        end
        tick60 = 1'b1;
        step(70);
        check("sat_overrun_partial", overrun_count, 69);
        step(230);
        tick60 = 1'b0;
        wait_until(t0 + 360);
        check("sat_overrun_255", overrun_count, 255);
        check("sat_frame_count", frame_count, 6);
        check("sat_timeout_err", timeout_err, 1);
        check("sat_busy", busy, 0);
        check("events_all_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
